phy_rx_serial_to_parallel: RTL and testbench

Per-lane receive deserializer of the PHY RX path. It sits directly upstream of the lane-1 2-to-4 demultiplexer. It converts one serial lane sampled at `clk_16f` into bytes and aligns byte boundaries on the comma character. After a run of aligned commas it declares the lane active, then presents each data byte with a valid flag and a one-cycle byte strobe. Comma bytes seen after lock are idle fill and never carry valid.

---
 rtl/phy_rx_pkg.sv | 13 +
 rtl/phy_rx_serial_to_parallel.sv | 112 +++++++++++
 tb/tb_phy_rx_serial_to_parallel.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared constants and state encoding for the PHY RX lane deserializer
package phy_rx_pkg;

  localparam int          BYTE_W        = 8;
  localparam logic [7:0]  COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    ALIGN  = 2'b01,
    LOCKED = 2'b10
  } rx_state_e;

endpackage

// File: rtl/phy_rx_serial_to_parallel.sv
// rtl/phy_rx_serial_to_parallel.sv - per-lane serial-to-byte deserializer with comma alignment and lock
module phy_rx_serial_to_parallel
  import phy_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int                LOCK_COUNT = 4
) (
  input  logic              clk_16f,
  input  logic              reset_L,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              byte_stb
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [BYTE_W-1:0] r_sr;
  logic [2:0]        r_bit_cnt;
  logic [3:0]        r_bc_cnt;
  logic [BYTE_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_active;
  logic              r_byte_stb;

  logic [BYTE_W-1:0] w_nxt;
  logic              w_is_comma;
  logic              w_boundary;
  logic [3:0]        w_bc_inc;
  logic              w_lock_hit;

  // w_nxt is the byte completed by the bit sampled at this edge
  assign w_nxt      = {r_sr[BYTE_W-2:0], data_in};
  assign w_is_comma = (w_nxt == COMMA);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_bc_inc   = r_bc_cnt + 4'd1;
  assign w_lock_hit = (w_bc_inc == LOCK_CNT);

  always_ff @(posedge clk_16f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEARCH: if (w_is_comma) w_state_nxt = ALIGN;
      ALIGN: begin
        if (w_boundary) begin
          if (!w_is_comma)     w_state_nxt = SEARCH;
          else if (w_lock_hit) w_state_nxt = LOCKED;
        end
      end
      LOCKED:  w_state_nxt = LOCKED;
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_16f or negedge reset_L) begin
    if (!reset_L) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_bc_cnt    <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
      r_byte_stb  <= 1'b0;
    end else begin
      r_sr       <= w_nxt;
      r_active   <= (w_state_nxt == LOCKED);
      // the locking boundary itself is seen in ALIGN, so it never strobes
      r_byte_stb <= (r_state == LOCKED) && w_boundary;

      case (r_state)
        SEARCH: begin
          if (w_is_comma) begin
            r_bit_cnt <= '0;
            r_bc_cnt  <= 4'd1;
          end
        end
        ALIGN: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) r_bc_cnt <= w_is_comma ? w_bc_inc : 4'd0;
        end
        LOCKED: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_comma) begin
              r_valid_out <= 1'b0;
            end else begin
              r_data_out  <= w_nxt;
              r_valid_out <= 1'b1;
            end
          end
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign active    = r_active;
  assign byte_stb  = r_byte_stb;

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// tb/tb_phy_rx_serial_to_parallel.sv - directed table-driven bench for the lane deserializer
module tb_phy_rx_serial_to_parallel;
  import phy_rx_pkg::*;

  logic       clk_16f = 1'b0;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_stb;

  int checks = 0;
  int errors = 0;

  phy_rx_serial_to_parallel dut (
    .clk_16f  (clk_16f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .byte_stb (byte_stb)
  );

  always #5 clk_16f = ~clk_16f;

  // rst: reset the lane and send 3 noise bits (011) before this byte
  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic       e_active;
    logic       e_stb;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  logic       p_active;
  logic       p_valid;
  logic [7:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_16f);
    data_in = b;
    @(posedge clk_16f);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_16f);
    reset_L = 1'b0;
    repeat (4) begin
      @(negedge clk_16f);
      data_in = 1'($urandom);
    end
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_stb", 32'(byte_stb), 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(SEARCH));
    data_in = 1'b0;
    reset_L = 1'b1;
    p_active = 1'b0;
    p_valid  = 1'b0;
    p_data   = 8'h00;
  endtask

  // Sends a byte MSB first; mid-byte edges must hold prior outputs with no strobe
  task automatic apply_vec(input vec_t v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v.din[i]);
      if (i != 0) begin
        chk("mid_stb", 32'(byte_stb), 32'h0);
        chk("mid_active", 32'(active), 32'(p_active));
        chk("mid_valid", 32'(valid_out), 32'(p_valid));
        chk("mid_data", 32'(data_out), 32'(p_data));
      end
    end
    chk("end_active", 32'(active), 32'(v.e_active));
    chk("end_stb", 32'(byte_stb), 32'(v.e_stb));
    chk("end_valid", 32'(valid_out), 32'(v.e_valid));
    chk("end_data", 32'(data_out), 32'(v.e_data));
    p_active = v.e_active;
    p_valid  = v.e_valid;
    p_data   = v.e_data;
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic a,
                              input logic s, input logic vl, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.din = d; v.e_active = a; v.e_stb = s; v.e_valid = vl; v.e_data = ed;
    return v;
  endfunction

  initial begin
    reset_L = 1'b0;
    data_in = 1'b0;
    p_active = 1'b0;
    p_valid  = 1'b0;
    p_data   = 8'h00;

    // broken run: the 0x12 drops the count, only the final run of four locks
    vecs.push_back(mk(1, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h12, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 1, 0, 0, 8'h00));
    // clean lock after noise, then data, idle comma and misaligned-comma bytes
    vecs.push_back(mk(1, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hBC, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'hA5, 1, 1, 1, 8'hA5));
    vecs.push_back(mk(0, 8'h3C, 1, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 8'hBC, 1, 1, 0, 8'h3C));
    vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 8'hFF));
    vecs.push_back(mk(0, 8'h5E, 1, 1, 1, 8'h5E));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 8'h00));
    vecs.push_back(mk(0, 8'hC3, 1, 1, 1, 8'hC3));

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) begin
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
      end
      apply_vec(vecs[k]);
    end

    // asynchronous reset 3 bits into a locked byte clears outputs before any edge
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_data_out", 32'(data_out), 32'h0);
    chk("async_valid", 32'(valid_out), 32'h0);
    chk("async_active", 32'(active), 32'h0);
    chk("async_stb", 32'(byte_stb), 32'h0);
    @(negedge clk_16f);
    data_in = 1'b0;
    @(negedge clk_16f);
    reset_L = 1'b1;
    p_active = 1'b0;
    p_valid  = 1'b0;
    p_data   = 8'h00;

    // relock must land exactly on the 4th comma's last bit
    apply_vec(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    apply_vec(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    apply_vec(mk(0, 8'hBC, 0, 0, 0, 8'h00));
    apply_vec(mk(0, 8'hBC, 1, 0, 0, 8'h00));
    apply_vec(mk(0, 8'h77, 1, 1, 1, 8'h77));
    send_bit(1'b0);
    chk("stb_width", 32'(byte_stb), 32'h0);
    chk("hold_data", 32'(data_out), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
